// File: rtl/ad7991_pkg.sv
// Shared types and constants for the AD7991 I2C responder: state encoding,
// default address and reset config, word-format and cfg field positions.
package ad7991_pkg;

  localparam logic [6:0] AD7991_ADDR      = 7'h28;
  localparam logic [7:0] AD7991_CFG_RESET = 8'hF0;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_W      = 12;
  localparam int unsigned CH_DATA_W = NUM_CH * CH_W;

  // Conversion word: {2'b00, ch_id[1:0], data[11:0]}
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned WORD_ID_LSB = 12;
  localparam int unsigned WORD_ID_W   = 2;

  // cfg[7:4] channel enables (bit 4 = CH0 .. bit 7 = CH3), cfg[3:0] stored only
  localparam int unsigned CFG_EN_LSB = 4;
  localparam int unsigned CFG_EN_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_IGNORE
  } state_e;

  function automatic logic [CFG_EN_W-1:0] eff_en(input logic [CFG_EN_W-1:0] en_raw);
    eff_en = (en_raw == 4'd0) ? 4'b0001 : en_raw;
  endfunction

  // Next enabled channel after cur, wrapping; smallest forward offset wins.
  function automatic logic [WORD_ID_W-1:0] next_ch(input logic [WORD_ID_W-1:0] cur,
                                                   input logic [CFG_EN_W-1:0]  en);
    logic [WORD_ID_W-1:0] c;
    next_ch = cur;
    for (int i = 4; i >= 1; i--) begin
      c = cur + 2'(i);
      if (en[c]) next_ch = c;
    end
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input logic [WORD_ID_W-1:0] ch,
                                                input logic [CH_W-1:0]      d);
    mk_word = {2'b00, ch, d};
  endfunction

endpackage

// File: rtl/ad7991_i2c_responder_line_sync.sv
// i2c_line_sync: 2-FF synchronizer, optional 3-sample majority filter
// (AD7991_RESP_GLITCH_FILTER_EN), registered level with rise/fall pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       filt;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

`ifdef AD7991_RESP_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  // Majority of the current and two previous synchronized samples
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign filt = maj_q;
`else
  assign filt = sync_q[1];
`endif

  // Idle bus level is high, so everything resets to 1 to avoid false edges
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= filt;
      rise_q  <= filt & ~level_q;
      fall_q  <= ~filt & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ad7991_i2c_responder.sv
// AD7991 I2C target emulation: config byte on writes, 2-byte conversion words on
// reads. AD7991_RESP_GLITCH_FILTER_EN enables majority filtering of SCL/SDA.
module ad7991_i2c_responder
  import ad7991_pkg::*;
#(
  parameter logic [6:0] ADDR      = AD7991_ADDR,
  parameter logic [7:0] CFG_RESET = AD7991_CFG_RESET
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  input  logic [CH_DATA_W-1:0] ch_data,
  output logic [7:0]           cfg,
  output logic                 busy,
  output logic [15:0]          rd_word_cnt
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic [CH_W-1:0] chan [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign chan[g] = ch_data[g*CH_W +: CH_W];
  end

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         shift_q, shift_d;
  logic [6:0]         tx_q, tx_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [WORD_ID_W-1:0] ch_q, ch_d;
  logic               byte_sel_q, byte_sel_d;
  logic               rw_q, rw_d;
  logic               first_wr_q, first_wr_d;
  logic               ack_rise_q, ack_rise_d;
  logic [7:0]         cfg_q, cfg_d;
  logic               busy_q, busy_d;
  logic               sda_oe_q, sda_oe_d;
  logic [15:0]        rd_cnt_q, rd_cnt_d;
  logic [WORD_W-1:0]  lat_word;

  // Word for the current channel, captured only when a word is latched
  assign lat_word = mk_word(ch_q, chan[ch_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      tx_q       <= 7'd0;
      byte1_q    <= 8'd0;
      ch_q       <= 2'd0;
      byte_sel_q <= 1'b0;
      rw_q       <= 1'b0;
      first_wr_q <= 1'b0;
      ack_rise_q <= 1'b0;
      cfg_q      <= CFG_RESET;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rd_cnt_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      byte1_q    <= byte1_d;
      ch_q       <= ch_d;
      byte_sel_q <= byte_sel_d;
      rw_q       <= rw_d;
      first_wr_q <= first_wr_d;
      ack_rise_q <= ack_rise_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    byte1_d    = byte1_q;
    ch_d       = ch_q;
    byte_sel_d = byte_sel_q;
    rw_d       = rw_q;
    first_wr_d = first_wr_q;
    ack_rise_d = ack_rise_q;
    cfg_d      = cfg_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    rd_cnt_d   = rd_cnt_q;

    // STOP is checked first so it wins over any coincident SCL event
    if (sda_rise && scl_lvl) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (sda_fall && scl_lvl) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q == ADDR) begin
                state_d    = S_ADDR_ACK;
                ack_rise_d = 1'b0;
                rw_d       = sda_lvl;
                first_wr_d = 1'b1;
                byte_sel_d = 1'b0;
                ch_d       = next_ch(2'd3, eff_en(cfg_q[CFG_EN_LSB +: CFG_EN_W]));
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            ack_rise_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              state_d   = S_RD_BYTE;
              bit_cnt_d = 3'd0;
              byte1_d   = lat_word[7:0];
              tx_d      = lat_word[14:8];
              sda_oe_d  = ~lat_word[15];
            end else begin
              state_d   = S_WR_BYTE;
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = S_WR_ACK;
              ack_rise_d = 1'b0;
              first_wr_d = 1'b0;
              if (first_wr_q) cfg_d = {shift_q, sda_lvl};
            end
          end
        end
        S_WR_ACK: begin
          if (scl_rise) begin
            ack_rise_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_oe_d = 1'b1;
            end else begin
              state_d   = S_WR_BYTE;
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              state_d    = S_RD_ACK;
              ack_rise_d = 1'b0;
              sda_oe_d   = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = {tx_q[5:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (byte_sel_q) rd_cnt_d = rd_cnt_q + 16'd1;
            if (!sda_lvl) begin
              ack_rise_d = 1'b1;
              if (byte_sel_q) ch_d = next_ch(ch_q, eff_en(cfg_q[CFG_EN_LSB +: CFG_EN_W]));
            end else begin
              state_d = S_IGNORE;
            end
          end else if (scl_fall && ack_rise_q) begin
            state_d   = S_RD_BYTE;
            bit_cnt_d = 3'd0;
            if (!byte_sel_q) begin
              byte_sel_d = 1'b1;
              tx_d       = byte1_q[6:0];
              sda_oe_d   = ~byte1_q[7];
            end else begin
              byte_sel_d = 1'b0;
              byte1_d    = lat_word[7:0];
              tx_d       = lat_word[14:8];
              sda_oe_d   = ~lat_word[15];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe      = sda_oe_q;
  assign cfg         = cfg_q;
  assign busy        = busy_q;
  assign rd_word_cnt = rd_cnt_q;

endmodule

// File: tb/tb_ad7991_i2c_responder.sv
// Directed bench for ad7991_i2c_responder: an open-drain I2C master model drives
// writes, reads, a foreign address, mid-transfer reset and an SCL glitch.
module tb_ad7991_i2c_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl_m;
  logic        sda_m;
  logic [47:0] ch_data;
  logic        sda_oe;
  logic [7:0]  cfg;
  logic        busy;
  logic [15:0] rd_word_cnt;
  logic        sda_line;
  int          total = 0;
  int          bad = 0;
  int          oe_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  ad7991_i2c_responder dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .ch_data    (ch_data),
    .cfg        (cfg),
    .busy       (busy),
    .rd_word_cnt(rd_word_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(1);
  endtask

  task automatic bus_stop;
    tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // One SCL period; optional 1-clk low glitch during the high phase
  task automatic put_bit(input logic b, input logic glitch, output logic seen);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    if (glitch) begin
      tick(4); scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(Q - 5);
    end else begin
      tick(Q);
    end
    seen = sda_line;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack_n);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], i == glitch_bit, s);
    put_bit(1'b1, 1'b0, ack_n);
  endtask

  task automatic read_byte(input logic mack_n, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    put_bit(mack_n, 1'b0, s);
  endtask

  task automatic test_reset;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (cfg !== 8'hF0) begin bad++; $display("FAIL rst_cfg got=%h exp=f0", cfg); end
    total++; if (rd_word_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", rd_word_cnt); end
  endtask

  task automatic test_write;
    logic a;
    bus_start;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
    write_byte(8'h50, -1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=0", a); end
    write_byte(8'h30, -1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_data_ack got=%b exp=0", a); end
    total++; if (cfg !== 8'h30) begin bad++; $display("FAIL wr_cfg got=%h exp=30", cfg); end
    bus_stop;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_read;
    logic a;
    logic [7:0] d;
    logic [7:0] exp [4] = '{8'h0A, 8'hBC, 8'h11, 8'h23};
    bus_start;
    write_byte(8'h51, -1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
    for (int i = 0; i < 4; i++) begin
      read_byte(i == 3, d);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL rd_byte%0d got=%h exp=%h", i, d, exp[i]); end
    end
    bus_stop;
    total++; if (rd_word_cnt !== 16'd2) begin bad++; $display("FAIL rd_cnt got=%0d exp=2", rd_word_cnt); end
  endtask

  task automatic test_bad_addr;
    logic a;
    int oe0;
    oe0 = oe_cnt;
    bus_start;
    write_byte(8'h52, -1, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL bad_addr_nack got=%b exp=1", a); end
    write_byte(8'h80, -1, a);
    bus_stop;
    total++; if (oe_cnt !== oe0) begin bad++; $display("FAIL bad_addr_drive got=%0d exp=%0d", oe_cnt, oe0); end
    total++; if (cfg !== 8'h30) begin bad++; $display("FAIL bad_addr_cfg got=%h exp=30", cfg); end
  endtask

  task automatic test_wrap;
    logic a;
    logic [7:0] d;
    bus_start;
    write_byte(8'h50, -1, a);
    write_byte(8'h80, -1, a);
    bus_stop;
    total++; if (cfg !== 8'h80) begin bad++; $display("FAIL wrap_cfg got=%h exp=80", cfg); end
    bus_start;
    write_byte(8'h51, -1, a);
    for (int w = 0; w < 3; w++) begin
      read_byte(1'b0, d);
      total++; if (d !== 8'h35) begin bad++; $display("FAIL wrap_b0_w%0d got=%h exp=35", w, d); end
      read_byte(w == 2, d);
      total++; if (d !== 8'hA7) begin bad++; $display("FAIL wrap_b1_w%0d got=%h exp=a7", w, d); end
    end
    bus_stop;
    total++; if (rd_word_cnt !== 16'd5) begin bad++; $display("FAIL wrap_cnt got=%0d exp=5", rd_word_cnt); end
  endtask

  task automatic test_reset_mid;
    logic a;
    logic s;
    logic [7:0] d;
    bus_start;
    write_byte(8'h51, -1, a);
    read_byte(1'b0, d);
    total++; if (d !== 8'h35) begin bad++; $display("FAIL mid_b0 got=%h exp=35", d); end
    put_bit(1'b1, 1'b0, s);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL mid_b1_bit7 got=%b exp=1", s); end
    tick(Q);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL mid_pre_drive got=%b exp=1", sda_oe); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_sda_oe got=%b exp=0", sda_oe); end
    total++; if (cfg !== 8'hF0) begin bad++; $display("FAIL mid_rst_cfg got=%h exp=f0", cfg); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    total++; if (rd_word_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", rd_word_cnt); end
    tick(1);
    reset = 1'b0;
    tick(2);
    bus_start;
    write_byte(8'h51, -1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL post_rst_ack got=%b exp=0", a); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL post_rst_ch0 got=%h exp=0a", d); end
    bus_stop;
    total++; if (rd_word_cnt !== 16'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", rd_word_cnt); end
  endtask

  task automatic test_glitch;
    logic a;
    logic [7:0] exp_cfg;
`ifdef AD7991_RESP_GLITCH_FILTER_EN
    exp_cfg = 8'h30;
`else
    exp_cfg = 8'h18;
`endif
    bus_start;
    write_byte(8'h50, -1, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL glitch_addr_ack got=%b exp=0", a); end
    write_byte(8'h30, 7, a);
    bus_stop;
    total++; if (cfg !== exp_cfg) begin bad++; $display("FAIL glitch_cfg got=%h exp=%h", cfg, exp_cfg); end
  endtask

  initial begin
    ch_data = {12'h5A7, 12'h456, 12'h123, 12'hABC};
    test_reset;
    test_write;
    test_read;
    test_bad_addr;
    test_wrap;
    test_reset_mid;
    test_glitch;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad7991_i2c_responder.md
# ad7991_i2c_responder

Synthesizable I2C target emulating the AD7991 4-channel 12-bit ADC, for the opposite end of the `pmod_adc_ad7991` bus. It accepts a configuration byte on write transactions and, on read transactions, returns 2-byte conversion words taken from parallel channel inputs. It serves as the in-system responder model for loopback testing and bench verification of the ADC master without Pmod hardware.

## Interface
- `ADDR`, 7'h28: 7-bit target address matched.
- `CFG_RESET`, 8'hF0: configuration register value after reset (all channels enabled).
- `clk`  in  1: system clock; oversamples SCL/SDA (clk ≥ 20× SCL).
- `reset`  in  1: synchronous, active-high reset.
- `scl_in`  in  1: raw SCL line level.
- `sda_in`  in  1: raw SDA line level.
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release. Reset 0.
- `ch_data`  in  4×12: conversion values for CH0..CH3.
- `cfg`  out  8: current configuration register. Reset `CFG_RESET`.
- `busy`  out  1: high between START and STOP. Reset 0.
- `rd_word_cnt`  out  16: completed read words, wraps at 16'hFFFF→0. Reset 0.

## Operation
- SCL/SDA pass through 2-FF synchronizers; edges detected on synchronized values.
- START: SDA fall while SCL high → state `ADDR`, bit counter 0, `busy`=1. Repeated START accepted in any state.
- STOP: SDA rise while SCL high → `IDLE`, `sda_oe`=0, `busy`=0.
- States: `IDLE`, `ADDR`, `ADDR_ACK`, `WR_BYTE`, `WR_ACK`, `RD_BYTE`, `RD_ACK`, `IGNORE`.
- `ADDR`: shift 8 bits MSB first on SCL rise. Address ≠ `ADDR` → `IGNORE` (no drive until next START/STOP). Match → `ADDR_ACK`, drive ACK for one SCL period.
- Write (R/W=0): `WR_BYTE` shifts 8 bits; first byte is written to `cfg` on 8th SCL rise; subsequent bytes ACKed and discarded. Each byte ACKed in `WR_ACK`.
- Read (R/W=1): on leaving `ADDR_ACK`, latch the word for the current channel: byte0 = {2'b00, ch_id[1:0], data[11:8]}, byte1 = data[7:0]. Bits shifted out MSB first in `RD_BYTE`; in `RD_ACK`, SDA is released and the master bit is sampled on SCL rise.
- Master ACK after byte0 → byte1. Master ACK after byte1 → `rd_word_cnt`++, advance to the next enabled channel, latch a new word. Master NACK → `rd_word_cnt`++ only if byte1 was NACKed, then `IGNORE` until STOP/START.
- Channel order: enables are `cfg[7:4]` = CH3..CH0. Ascending order, wrapping to the lowest enabled channel. `cfg[7:4]`=0 is treated as CH0 only. The pointer resets to the lowest enabled channel at each address match.
- `cfg[3:0]` is stored but has no functional effect.

## Timing
- Input latency: 2 clk from raw line to synchronized value; edge pulse 1 clk later.
- `sda_oe` changes only in the clk after a synchronized SCL-fall pulse. It is never changed while SCL is high.
- Data is sampled in the clk after a synchronized SCL-rise pulse.
- `ch_data` is sampled exactly at word latch. Later changes do not affect a word in flight.
- `cfg` updates 1 clk after the 8th SCL rise of the first write byte.
- Simultaneous START/STOP detection cannot occur. If STOP and SCL-fall coincide, STOP wins.
- `reset` mid-transfer: every output returns to its reset value on the next clk and SDA is released immediately. A bus with SCL low requires a START.

## Configuration
- `AD7991_RESP_GLITCH_FILTER_EN`: when defined, each synchronized line passes through a 3-sample majority filter (+2 clk latency), so single-clk pulses are rejected. When undefined, no filter and latency is as above.

## Structure
- Package `ad7991_pkg`: state enum, `AD7991_ADDR` default, word-format bit positions, cfg field positions.
- Sub-module `i2c_line_sync`: synchronizer, optional majority filter, rise/fall pulses; instantiated once each for SCL and SDA.

## Test plan
- Write 0x28/W, byte 0x30 → both ACKs low, `cfg`=8'h30 after the byte, STOP → `busy`=0.
- `cfg`=0x30, CH0=12'hABC, CH1=12'h123, read 4 bytes (ACK, ACK, ACK, NACK) → 0x0A,0xBC,0x11,0x23, `rd_word_cnt`=2.
- Address 0x29 → no ACK (SDA released for the whole frame), `cfg` unchanged.
- `cfg`=0x80, read 3 words → every byte0 = 0x3x with CH3 data, wrap verified.
- Reset asserted mid-byte1 of a read → `sda_oe`=0 next clk, `cfg`=0xF0. A new START/read returns CH0 first.
- With `AD7991_RESP_GLITCH_FILTER_EN`, 1-clk SCL glitch inside a bit → shift count unaffected, correct byte received. Without the macro → extra bit counted.
